// File: rtl/mul_share_sequencer_pkg.sv
// Shared definitions for the multiplier-sharing sequencer.
// FSM encoding and default sizing.
package mul_share_sequencer_pkg;
  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mul_share_sequencer_rr_arbiter.sv
// Rotating-priority arbiter: first valid request at or after ptr_i.
// Purely combinational, one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);
  logic           hit;
  logic [IDW-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    hit     = 1'b0;
    j       = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr_i) + k) % NREQ);
      if (!hit && req_i[j]) begin
        hit        = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end
endmodule

// File: rtl/mul_share_sequencer.sv
// One shift-add multiplier shared by NREQ requesters, round-robin
// arbitration, product returned with requester id on valid/ready.
module mul_share_sequencer
  import mul_share_sequencer_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_product,
  output logic              busy
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  id_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2*W-1:0]  acc_q;
  logic [2*W-1:0]  acc_d;
  logic [CW-1:0]   cnt_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [2*W-1:0]  rsp_product_q;
  logic            busy_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic            idle;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .grant_o(gnt),
    .idx_o  (gidx)
  );

  // The unused encoding 2'd3 behaves as IDLE.
  assign idle = (state_q != S_MUL) && (state_q != S_RESP);
  assign req_ready = idle ? (gnt & {NREQ{~rst}}) : '0;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  assign acc_d = acc_q +
    (b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W-1)) begin
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_product_q <= acc_d;
            rsp_id_q      <= id_q;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (|gnt) begin
            state_q <= S_MUL;
            busy_q  <= 1'b1;
            a_q     <= a_sel;
            b_q     <= b_sel;
            id_q    <= gidx;
            acc_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= (int'(gidx) == NREQ-1) ? '0 : gidx + 1'b1;
          end
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_product = rsp_product_q;
  assign busy        = busy_q;
endmodule
